irq_ctrl: RTL
=============

# irq_ctrl

Interrupt manager for the simple RISC-V core, sitting beside the control FSM. It detects rising edges on external interrupt lines, holds them pending and raises `IRQ` to the control FSM. It supplies the PC to load on ISR entry (fixed vector) and on `mret` (saved return PC), and answers CSR reads for the CSR-read writeback path.

## Interface
- `NUM_IRQ`, 8: number of interrupt inputs, 1..16.
- `ISR_VECTOR`, 32'h0000_0010: PC loaded on ISR entry.
- `CLK`  in  1  single clock; all state updates on rising edge.
- `RES`  in  1  reset, asynchronous, active-high.
- `IRQ_IN`  in  NUM_IRQ  external interrupt lines; a rising edge requests service.
- `ENTER_ISR`  in  1  from control FSM; high for exactly one cycle in its ISR-entry state.
- `PC_SEL`  in  1  from control FSM; high in ISR-entry and MRET states.
- `PC`  in  32  current program counter (return address during the ISR-entry cycle).
- `CSR_ADDR`  in  12  CSR address, INSTR[31:20].
- `IRQ`  out  1  any interrupt pending.
- `ISR_PC`  out  32  PC load value when `PC_SEL`=1.
- `CSR_DATA`  out  32  read data for `CSR_ADDR`, combinational.

## Operation
- Registers: `pending[NUM_IRQ-1:0]`, `irq_prev[NUM_IRQ-1:0]`, `epc[31:0]`, `cause_idx[4:0]`, `in_service`.
- FSM has two states, IDLE (`in_service`=0) and SERVICE (`in_service`=1).
- IDLE -> SERVICE on `ENTER_ISR`.
- SERVICE -> IDLE on MRET, i.e. `PC_SEL`=1 with `ENTER_ISR`=0.
- Edge detect: `edge = sampled & ~irq_prev`; `irq_prev <= sampled` every cycle.
- Pending: each bit is set by its edge and cleared when it is selected on `ENTER_ISR`. Set wins over clear on the same bit in the same cycle.
- `IRQ = |pending`, independent of `in_service`. The control FSM masks nesting itself.
- On `ENTER_ISR`:
  - `epc <= PC`.
  - `cause_idx <=` lowest set index of `pending`; that bit is cleared.
  - If `pending` is 0, `cause_idx <= 5'h1F` and nothing is cleared.
- `ISR_PC = ENTER_ISR ? ISR_VECTOR : epc`.
- MRET followed directly by ISR entry re-captures `epc` from `PC`, which already holds the old `epc`. The return address is therefore preserved.
- CSR reads:
  - 0x300 mstatus: bit3 = ~`in_service`, other bits 0.
  - 0x341 mepc: `epc`.
  - 0x342 mcause: {1'b1, 26'b0, `cause_idx`}.
  - 0x344 mip: `pending` zero-extended.
  - Any other address reads 0.
- No CSR writes exist.

## Timing
- Reset values: `pending`=0, `irq_prev`=0, `epc`=0, `cause_idx`=0, `in_service`=0; therefore `IRQ`=0, `ISR_PC`=0, `CSR_DATA` follows these values.
- An `IRQ_IN` bit sampled high at edge k with `irq_prev` low sets the pending bit; `IRQ`=1 from edge k onward (1-cycle latency).
- Edge-to-`IRQ` latency is 3 cycles when the synchronizer is compiled in.
- `ISR_PC` and `CSR_DATA` are combinational; they are valid in the same cycle as `ENTER_ISR`/`PC_SEL`/`CSR_ADDR`.
- `epc`, `cause_idx` and the pending clear take effect after the `ENTER_ISR` edge, so they are visible in the first ISR instruction.
- A line held high is one request. A new request needs a low sample between two high samples.
- Reset asserted mid-ISR clears everything asynchronously; pending requests are lost.

## Configuration
- `IRQ_CTRL_SYNC_EN` defined: a 2-flop synchronizer is placed on each `IRQ_IN` bit ahead of the edge detector. Total latency is 3 cycles; `IRQ_IN` may be asynchronous.
- Not defined: `IRQ_IN` is sampled directly. Latency is 1 cycle; `IRQ_IN` must be synchronous to `CLK`.

## Structure
- CSR address constants (`CSR_MSTATUS`, `CSR_MEPC`, `CSR_MCAUSE`, `CSR_MIP`) and the no-source cause value 5'h1F go in `proc_defines.v`.
- One sub-module, `irq_edge_detect`: per-bit optional synchronizer plus rising-edge pulse, parameterised on width.

## Test plan
- Reset, then `IRQ_IN`=0 for 10 cycles -> `IRQ`=0, `ISR_PC`=0, CSR 0x300 reads 32'h8.
- Pulse `IRQ_IN[2]`, then `ENTER_ISR` with `PC`=0x120 -> `ISR_PC`=0x10 during entry; afterwards mepc=0x120, mcause=0x80000002, mip=0, mstatus=0, `IRQ`=0.
- Raise `IRQ_IN[5]` and `IRQ_IN[1]` in the same cycle, then `ENTER_ISR` -> mcause=0x80000001, mip=0x20, `IRQ` stays 1.
- MRET (`PC_SEL`=1, `ENTER_ISR`=0) with pending=0x20 -> `ISR_PC`=epc, mstatus=0x8.
  - Then `ENTER_ISR` with `PC`=epc -> mepc unchanged, mcause=0x80000005.
- New edge on bit 3 in the same cycle as `ENTER_ISR` selects bit 3 -> bit 3 remains pending.
- Assert `RES` asynchronously mid-ISR with pending=0x0F -> all registers 0 before the next clock edge; `IRQ`=0.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants, FSM state type and priority helper for the interrupt manager.
package irq_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [4:0]  CAUSE_NONE  = 5'h1F;
  localparam int          MAX_IRQ     = 16;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } irq_state_e;

  // Lowest set bit wins; an empty vector yields CAUSE_NONE.
  function automatic logic [4:0] lowest_set(input logic [MAX_IRQ-1:0] vec);
    logic [4:0] idx;
    idx = CAUSE_NONE;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_ctrl_edge_detect.sv
// Per-line rising-edge pulse generator; IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer per line.
module irq_edge_detect #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] irq_i,
  output logic [WIDTH-1:0] edge_o
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic sampled;
    logic irq_prev_q;

`ifdef IRQ_CTRL_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= 2'b00;
      else       sync_q <= {sync_q[0], irq_i[gi]};
    end

    assign sampled = sync_q[1];
`else
    assign sampled = irq_i[gi];
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) irq_prev_q <= 1'b0;
      else       irq_prev_q <= sampled;
    end

    assign edge_o[gi] = sampled & ~irq_prev_q;
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt manager: edge-triggered pending bits, ISR entry/return PC and read-only CSRs.
// Optional build macro IRQ_CTRL_SYNC_EN synchronizes IRQ_IN (3-cycle edge-to-IRQ latency).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NUM_IRQ    = 8,
  parameter logic [31:0] ISR_VECTOR = 32'h0000_0010
) (
  input  logic               CLK,
  input  logic               RES,
  input  logic [NUM_IRQ-1:0] IRQ_IN,
  input  logic               ENTER_ISR,
  input  logic               PC_SEL,
  input  logic [31:0]        PC,
  input  logic [11:0]        CSR_ADDR,
  output logic               IRQ,
  output logic [31:0]        ISR_PC,
  output logic [31:0]        CSR_DATA
);

  irq_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [31:0]        epc_q, epc_d;
  logic [4:0]         cause_q, cause_d;

  logic [NUM_IRQ-1:0] edge_pulse;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [4:0]         sel_idx;
  logic               in_service;
  logic [31:0]        mip;

  irq_edge_detect #(.WIDTH(NUM_IRQ)) u_edge (
    .clk_i  (CLK),
    .rst_i  (RES),
    .irq_i  (IRQ_IN),
    .edge_o (edge_pulse)
  );

  assign sel_idx = lowest_set(MAX_IRQ'(pending_q));

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_clr
    assign clr_mask[gi] = ENTER_ISR && (sel_idx == 5'(gi));
  end

  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    // A fresh edge outranks the clear of the bit being serviced.
    pending_d = (pending_q & ~clr_mask) | edge_pulse;

    if (ENTER_ISR) begin
      epc_d   = PC;
      cause_d = sel_idx;
    end

    case (state_q)
      ST_IDLE:    if (ENTER_ISR)            state_d = ST_SERVICE;
      ST_SERVICE: if (PC_SEL && !ENTER_ISR) state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      epc_q     <= '0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
    end
  end

  assign in_service = (state_q == ST_SERVICE);
  assign IRQ        = |pending_q;
  assign ISR_PC     = ENTER_ISR ? ISR_VECTOR : epc_q;

  always_comb begin
    mip                = '0;
    mip[NUM_IRQ-1:0]   = pending_q;
  end

  always_comb begin
    CSR_DATA = '0;
    case (CSR_ADDR)
      CSR_MSTATUS: CSR_DATA = {28'b0, ~in_service, 3'b000};
      CSR_MEPC:    CSR_DATA = epc_q;
      CSR_MCAUSE:  CSR_DATA = {1'b1, 26'b0, cause_q};
      CSR_MIP:     CSR_DATA = mip;
      default:     CSR_DATA = '0;
    endcase
  end

endmodule
